mem_wb_pipe: RTL and testbench
==============================

// Module: mem_wb_pipe
// PURPOSE
//  Upstream (sender) end of the MEM->WB pipeline interface: registers the MEM-stage result and drives wb_pipe_*.
//  2-entry skid buffer (output reg + skid reg); mem_ready is registered, so no comb path from wb_pipe_ready upstream.
//  Sustains 1 instr/cycle with 1-cycle latency; absorbs one beat when WB deasserts wb_pipe_ready.
//  Honours wb_pipe_flush and a trap flush from the core control.
// PARAMETERS
//  XLEN    32  datapath width (`XLEN)
//  REG_AW  5   register-file address width (`REG_AW)
// PORTS
//  clk                  in   1        core clock
//  rst                  in   1        asynchronous, active-high reset
//  mem_valid            in   1        MEM stage presents a beat
//  mem_ready            out  1        buffer accepts beat (registered)
//  flush                in   1        trap/redirect flush from core control
//  mem_pc, mem_instruction                        in  XLEN each  payload
//  mem_rd_write, mem_rd_addr[REG_AW], mem_rd_data[XLEN]          in  payload
//  mem_csr_write/set/clear/read (1 each), mem_csr_info[XLEN], mem_csr_addr[12]  in  payload
//  mem_exc_pending, mem_exc_code[4], mem_exc_tval[XLEN], mem_exc_interrupt   in  payload
//  wb_pipe_ready        in   1        WB accepts current beat
//  wb_pipe_flush        in   1        WB-requested flush
//  wb_pipe_valid        out  1        beat valid toward WB
//  wb_pipe_<field>      out  same     registered copy of each mem_<field> above
// BEHAVIOUR
//  - States: EMPTY (no entry), ONE (output reg valid), TWO (output + skid valid).
//  - wb_pipe_valid = (state != EMPTY); mem_ready = (state != TWO), both direct from flops.
//  - Accept = mem_valid & mem_ready; Drain = wb_pipe_valid & wb_pipe_ready.
//  - EMPTY: accept -> out<=in, ONE.
//  - ONE: accept&drain -> out<=in, ONE; accept&!drain -> skid<=in, TWO; !accept&drain -> EMPTY.
//  - TWO: drain -> out<=skid, ONE; else hold. No accept possible (mem_ready=0).
//  - Flush (flush | wb_pipe_flush) has top priority: next state EMPTY, same-cycle accept dropped,
//    skid discarded; payload regs need not clear, valid must.
//  - Payload regs load only on the transitions above; otherwise hold (stable while valid & !ready).
//  - Entries with exc_pending=1 pass through unchanged; no payload modification in this block.
//  - Reset (async, any state): state=EMPTY, wb_pipe_valid=0, mem_ready=1, all wb_pipe_* payload=0.
//  - Ordering: beats leave in arrival order; no loss, no duplication under any valid/ready pattern.
// TESTING
//  1. Stream: ready=1, pc 0x0,0x4,0x8,0xC back-to-back -> wb_pipe_pc same seq 1 cycle later, no bubbles.
//  2. Backpressure: ready=0, send 0x100,0x104 -> mem_ready=0 after 2nd; release -> 0x100 then 0x104 on consecutive cycles.
//  3. Flush in TWO with mem_valid=1 (pc 0x200) -> next cycle wb_pipe_valid=0, mem_ready=1, 0x200 never seen.
//  4. Payload: rd_write=1 rd_addr=5 rd_data=0xDEADBEEF csr_read=1 csr_addr=0x300 exc_pending=1 exc_code=2 -> identical on wb_pipe_*.
//  5. Async rst asserted mid-TWO -> wb_pipe_valid=0, mem_ready=1 immediately; first beat after release passes normally.
//  6. 10k cycles random valid/ready/flush vs scoreboard -> in-order, zero loss/dup, mem_ready never comb on wb_pipe_ready.

Source files
------------

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: sender end of the MEM->WB pipeline interface.
// Two-entry skid buffer (output register + skid register). mem_ready and
// wb_pipe_valid come straight from flops, so wb_pipe_ready has no
// combinational path back to the MEM stage.
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   mem_valid/mem_ready upstream handshake (mem_ready registered)
//   flush               trap/redirect flush from core control
//   mem_*               MEM-stage result payload
//   wb_pipe_ready       WB accepts current beat
//   wb_pipe_flush       WB-requested flush
//   wb_pipe_valid       beat valid toward WB
//   wb_pipe_*           registered copy of each mem_* payload field
module mem_wb_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic              flush,
  input  logic [XLEN-1:0]   mem_pc,
  input  logic [XLEN-1:0]   mem_instruction,
  input  logic              mem_rd_write,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]   mem_rd_data,
  input  logic              mem_csr_write,
  input  logic              mem_csr_set,
  input  logic              mem_csr_clear,
  input  logic              mem_csr_read,
  input  logic [XLEN-1:0]   mem_csr_info,
  input  logic [11:0]       mem_csr_addr,
  input  logic              mem_exc_pending,
  input  logic [3:0]        mem_exc_code,
  input  logic [XLEN-1:0]   mem_exc_tval,
  input  logic              mem_exc_interrupt,
  input  logic              wb_pipe_ready,
  input  logic              wb_pipe_flush,
  output logic              wb_pipe_valid,
  output logic [XLEN-1:0]   wb_pipe_pc,
  output logic [XLEN-1:0]   wb_pipe_instruction,
  output logic              wb_pipe_rd_write,
  output logic [REG_AW-1:0] wb_pipe_rd_addr,
  output logic [XLEN-1:0]   wb_pipe_rd_data,
  output logic              wb_pipe_csr_write,
  output logic              wb_pipe_csr_set,
  output logic              wb_pipe_csr_clear,
  output logic              wb_pipe_csr_read,
  output logic [XLEN-1:0]   wb_pipe_csr_info,
  output logic [11:0]       wb_pipe_csr_addr,
  output logic              wb_pipe_exc_pending,
  output logic [3:0]        wb_pipe_exc_code,
  output logic [XLEN-1:0]   wb_pipe_exc_tval,
  output logic              wb_pipe_exc_interrupt
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instruction;
    logic              rd_write;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   rd_data;
    logic              csr_write;
    logic              csr_set;
    logic              csr_clear;
    logic              csr_read;
    logic [XLEN-1:0]   csr_info;
    logic [11:0]       csr_addr;
    logic              exc_pending;
    logic [3:0]        exc_code;
    logic [XLEN-1:0]   exc_tval;
    logic              exc_interrupt;
  } payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t   state_q, state_d;
  payload_t out_q, out_d;
  payload_t skid_q, skid_d;
  logic     valid_q, valid_d;
  logic     ready_q, ready_d;

  payload_t in_pl;
  logic     accept;
  logic     drain;
  logic     flush_any;

  always_comb begin
    in_pl               = '0;
    in_pl.pc            = mem_pc;
    in_pl.instruction   = mem_instruction;
    in_pl.rd_write      = mem_rd_write;
    in_pl.rd_addr       = mem_rd_addr;
    in_pl.rd_data       = mem_rd_data;
    in_pl.csr_write     = mem_csr_write;
    in_pl.csr_set       = mem_csr_set;
    in_pl.csr_clear     = mem_csr_clear;
    in_pl.csr_read      = mem_csr_read;
    in_pl.csr_info      = mem_csr_info;
    in_pl.csr_addr      = mem_csr_addr;
    in_pl.exc_pending   = mem_exc_pending;
    in_pl.exc_code      = mem_exc_code;
    in_pl.exc_tval      = mem_exc_tval;
    in_pl.exc_interrupt = mem_exc_interrupt;
  end

  assign accept    = mem_valid & ready_q;
  assign drain     = valid_q & wb_pipe_ready;
  assign flush_any = flush | wb_pipe_flush;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush_any) begin
      // Payload is left as-is; only occupancy is cleared.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            out_d   = in_pl;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            out_d = in_pl;
          end else if (accept) begin
            skid_d  = in_pl;
            state_d = TWO;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            out_d   = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Handshake flops are loaded from the next state so both outputs
    // are pure register outputs.
    valid_d = (state_d != EMPTY);
    ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign mem_ready             = ready_q;
  assign wb_pipe_valid         = valid_q;
  assign wb_pipe_pc            = out_q.pc;
  assign wb_pipe_instruction   = out_q.instruction;
  assign wb_pipe_rd_write      = out_q.rd_write;
  assign wb_pipe_rd_addr       = out_q.rd_addr;
  assign wb_pipe_rd_data       = out_q.rd_data;
  assign wb_pipe_csr_write     = out_q.csr_write;
  assign wb_pipe_csr_set       = out_q.csr_set;
  assign wb_pipe_csr_clear     = out_q.csr_clear;
  assign wb_pipe_csr_read      = out_q.csr_read;
  assign wb_pipe_csr_info      = out_q.csr_info;
  assign wb_pipe_csr_addr      = out_q.csr_addr;
  assign wb_pipe_exc_pending   = out_q.exc_pending;
  assign wb_pipe_exc_code      = out_q.exc_code;
  assign wb_pipe_exc_tval      = out_q.exc_tval;
  assign wb_pipe_exc_interrupt = out_q.exc_interrupt;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed and randomized checks for mem_wb_pipe.
module tb_mem_wb_pipe;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  logic              clk;
  logic              rst;
  logic              mem_valid;
  logic              mem_ready;
  logic              flush;
  logic [XLEN-1:0]   mem_pc;
  logic [XLEN-1:0]   mem_instruction;
  logic              mem_rd_write;
  logic [REG_AW-1:0] mem_rd_addr;
  logic [XLEN-1:0]   mem_rd_data;
  logic              mem_csr_write;
  logic              mem_csr_set;
  logic              mem_csr_clear;
  logic              mem_csr_read;
  logic [XLEN-1:0]   mem_csr_info;
  logic [11:0]       mem_csr_addr;
  logic              mem_exc_pending;
  logic [3:0]        mem_exc_code;
  logic [XLEN-1:0]   mem_exc_tval;
  logic              mem_exc_interrupt;
  logic              wb_pipe_ready;
  logic              wb_pipe_flush;
  logic              wb_pipe_valid;
  logic [XLEN-1:0]   wb_pipe_pc;
  logic [XLEN-1:0]   wb_pipe_instruction;
  logic              wb_pipe_rd_write;
  logic [REG_AW-1:0] wb_pipe_rd_addr;
  logic [XLEN-1:0]   wb_pipe_rd_data;
  logic              wb_pipe_csr_write;
  logic              wb_pipe_csr_set;
  logic              wb_pipe_csr_clear;
  logic              wb_pipe_csr_read;
  logic [XLEN-1:0]   wb_pipe_csr_info;
  logic [11:0]       wb_pipe_csr_addr;
  logic              wb_pipe_exc_pending;
  logic [3:0]        wb_pipe_exc_code;
  logic [XLEN-1:0]   wb_pipe_exc_tval;
  logic              wb_pipe_exc_interrupt;

  int unsigned total;
  int unsigned bad;

  mem_wb_pipe #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .mem_valid             (mem_valid),
    .mem_ready             (mem_ready),
    .flush                 (flush),
    .mem_pc                (mem_pc),
    .mem_instruction       (mem_instruction),
    .mem_rd_write          (mem_rd_write),
    .mem_rd_addr           (mem_rd_addr),
    .mem_rd_data           (mem_rd_data),
    .mem_csr_write         (mem_csr_write),
    .mem_csr_set           (mem_csr_set),
    .mem_csr_clear         (mem_csr_clear),
    .mem_csr_read          (mem_csr_read),
    .mem_csr_info          (mem_csr_info),
    .mem_csr_addr          (mem_csr_addr),
    .mem_exc_pending       (mem_exc_pending),
    .mem_exc_code          (mem_exc_code),
    .mem_exc_tval          (mem_exc_tval),
    .mem_exc_interrupt     (mem_exc_interrupt),
    .wb_pipe_ready         (wb_pipe_ready),
    .wb_pipe_flush         (wb_pipe_flush),
    .wb_pipe_valid         (wb_pipe_valid),
    .wb_pipe_pc            (wb_pipe_pc),
    .wb_pipe_instruction   (wb_pipe_instruction),
    .wb_pipe_rd_write      (wb_pipe_rd_write),
    .wb_pipe_rd_addr       (wb_pipe_rd_addr),
    .wb_pipe_rd_data       (wb_pipe_rd_data),
    .wb_pipe_csr_write     (wb_pipe_csr_write),
    .wb_pipe_csr_set       (wb_pipe_csr_set),
    .wb_pipe_csr_clear     (wb_pipe_csr_clear),
    .wb_pipe_csr_read      (wb_pipe_csr_read),
    .wb_pipe_csr_info      (wb_pipe_csr_info),
    .wb_pipe_csr_addr      (wb_pipe_csr_addr),
    .wb_pipe_exc_pending   (wb_pipe_exc_pending),
    .wb_pipe_exc_code      (wb_pipe_exc_code),
    .wb_pipe_exc_tval      (wb_pipe_exc_tval),
    .wb_pipe_exc_interrupt (wb_pipe_exc_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid         = 1'b0;
    flush             = 1'b0;
    wb_pipe_flush     = 1'b0;
    wb_pipe_ready     = 1'b1;
    mem_pc            = '0;
    mem_instruction   = '0;
    mem_rd_write      = 1'b0;
    mem_rd_addr       = '0;
    mem_rd_data       = '0;
    mem_csr_write     = 1'b0;
    mem_csr_set       = 1'b0;
    mem_csr_clear     = 1'b0;
    mem_csr_read      = 1'b0;
    mem_csr_info      = '0;
    mem_csr_addr      = '0;
    mem_exc_pending   = 1'b0;
    mem_exc_code      = '0;
    mem_exc_tval      = '0;
    mem_exc_interrupt = 1'b0;
  endtask

  logic [31:0] q[$];
  logic [31:0] next_pc;
  logic        m_accept;
  logic        m_drain;
  int unsigned drained;

  initial begin
    total   = 0;
    bad     = 0;
    drained = 0;
    idle_inputs();
    rst = 1'b1;
    #12;
    chk("rst_valid", 64'(wb_pipe_valid), 64'd0);
    chk("rst_ready", 64'(mem_ready), 64'd1);
    chk("rst_pc", 64'(wb_pipe_pc), 64'd0);
    chk("rst_rd_data", 64'(wb_pipe_rd_data), 64'd0);
    rst = 1'b0;
    tick();

    // 1. back-to-back stream, one-cycle latency, no bubbles
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1;
      mem_pc    = 32'(4 * i);
      tick();
      chk("stream_valid", 64'(wb_pipe_valid), 64'd1);
      chk("stream_pc", 64'(wb_pipe_pc), 64'(4 * i));
      chk("stream_ready", 64'(mem_ready), 64'd1);
    end
    mem_valid = 1'b0;
    tick();
    chk("stream_end_valid", 64'(wb_pipe_valid), 64'd0);

    // 2. backpressure fills the skid, release drains in order
    wb_pipe_ready = 1'b0;
    mem_valid     = 1'b1;
    mem_pc        = 32'h100;
    tick();
    chk("bp1_valid", 64'(wb_pipe_valid), 64'd1);
    chk("bp1_ready", 64'(mem_ready), 64'd1);
    mem_pc = 32'h104;
    tick();
    chk("bp2_ready", 64'(mem_ready), 64'd0);
    chk("bp2_pc", 64'(wb_pipe_pc), 64'h100);
    mem_valid     = 1'b0;
    wb_pipe_ready = 1'b1;
    tick();
    chk("bp3_pc", 64'(wb_pipe_pc), 64'h104);
    chk("bp3_valid", 64'(wb_pipe_valid), 64'd1);
    chk("bp3_ready", 64'(mem_ready), 64'd1);
    tick();
    chk("bp4_valid", 64'(wb_pipe_valid), 64'd0);

    // 3. flush while full with a beat offered
    wb_pipe_ready = 1'b0;
    mem_valid     = 1'b1;
    mem_pc        = 32'h180;
    tick();
    mem_pc = 32'h184;
    tick();
    chk("fl_full", 64'(mem_ready), 64'd0);
    mem_pc = 32'h200;
    flush  = 1'b1;
    tick();
    chk("fl_valid", 64'(wb_pipe_valid), 64'd0);
    chk("fl_ready", 64'(mem_ready), 64'd1);
    flush         = 1'b0;
    mem_valid     = 1'b0;
    wb_pipe_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_200", 64'(wb_pipe_valid), 64'd0);
    end
    // WB-side flush from ONE
    mem_valid     = 1'b1;
    mem_pc        = 32'h220;
    wb_pipe_ready = 1'b0;
    tick();
    mem_valid     = 1'b0;
    wb_pipe_flush = 1'b1;
    tick();
    chk("wbfl_valid", 64'(wb_pipe_valid), 64'd0);
    wb_pipe_flush = 1'b0;
    wb_pipe_ready = 1'b1;

    // 4. full payload pass-through, then held under stall
    mem_valid       = 1'b1;
    mem_pc          = 32'h400;
    mem_instruction = 32'h0000_0073;
    mem_rd_write    = 1'b1;
    mem_rd_addr     = 5'd5;
    mem_rd_data     = 32'hDEAD_BEEF;
    mem_csr_read    = 1'b1;
    mem_csr_info    = 32'h1234_5678;
    mem_csr_addr    = 12'h300;
    mem_exc_pending = 1'b1;
    mem_exc_code    = 4'd2;
    mem_exc_tval    = 32'hCAFE_0001;
    wb_pipe_ready   = 1'b0;
    tick();
    chk("pl_rd_write", 64'(wb_pipe_rd_write), 64'd1);
    chk("pl_rd_addr", 64'(wb_pipe_rd_addr), 64'd5);
    chk("pl_rd_data", 64'(wb_pipe_rd_data), 64'hDEADBEEF);
    chk("pl_csr_read", 64'(wb_pipe_csr_read), 64'd1);
    chk("pl_csr_write", 64'(wb_pipe_csr_write), 64'd0);
    chk("pl_csr_addr", 64'(wb_pipe_csr_addr), 64'h300);
    chk("pl_csr_info", 64'(wb_pipe_csr_info), 64'h12345678);
    chk("pl_exc_pending", 64'(wb_pipe_exc_pending), 64'd1);
    chk("pl_exc_code", 64'(wb_pipe_exc_code), 64'd2);
    chk("pl_exc_tval", 64'(wb_pipe_exc_tval), 64'hCAFE0001);
    chk("pl_instr", 64'(wb_pipe_instruction), 64'h73);
    idle_inputs();
    wb_pipe_ready = 1'b0;
    mem_rd_data   = 32'h1111_1111;
    tick();
    chk("pl_hold_data", 64'(wb_pipe_rd_data), 64'hDEADBEEF);
    chk("pl_hold_pc", 64'(wb_pipe_pc), 64'h400);
    wb_pipe_ready = 1'b1;
    tick();

    // 5. async reset mid-cycle while full
    wb_pipe_ready = 1'b0;
    mem_valid     = 1'b1;
    mem_pc        = 32'h500;
    tick();
    mem_pc = 32'h504;
    tick();
    chk("ar_full", 64'(mem_ready), 64'd0);
    mem_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 64'(wb_pipe_valid), 64'd0);
    chk("ar_ready", 64'(mem_ready), 64'd1);
    chk("ar_pc", 64'(wb_pipe_pc), 64'd0);
    #1;
    rst           = 1'b0;
    wb_pipe_ready = 1'b1;
    mem_valid     = 1'b1;
    mem_pc        = 32'h300;
    tick();
    chk("ar_after_valid", 64'(wb_pipe_valid), 64'd1);
    chk("ar_after_pc", 64'(wb_pipe_pc), 64'h300);
    mem_valid = 1'b0;
    tick();

    // 6. random traffic against a FIFO model (depth 2)
    idle_inputs();
    q.delete();
    next_pc = 32'h1000;
    for (int c = 0; c < 10000; c++) begin
      mem_valid     = ($urandom_range(0, 99) < 60);
      wb_pipe_ready = ($urandom_range(0, 99) < 55);
      flush         = ($urandom_range(0, 99) < 2);
      wb_pipe_flush = ($urandom_range(0, 99) < 2);
      mem_pc        = next_pc;
      #1;
      // Inputs have settled: a comb path ready->mem_ready would show here.
      chk("rnd_ready", 64'(mem_ready), 64'(q.size() < 2));
      chk("rnd_valid", 64'(wb_pipe_valid), 64'(q.size() > 0));
      if (q.size() > 0) chk("rnd_pc", 64'(wb_pipe_pc), 64'(q[0]));
      m_accept = mem_valid && (q.size() < 2);
      m_drain  = wb_pipe_ready && (q.size() > 0);
      if (flush || wb_pipe_flush) begin
        q.delete();
      end else begin
        if (m_drain) begin
          void'(q.pop_front());
          drained++;
        end
        if (m_accept) q.push_back(next_pc);
      end
      if (m_accept) next_pc = next_pc + 32'd4;
      tick();
    end
    chk("rnd_progress", 64'(drained > 1000), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
